// File: rtl/jtag_master_drv.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jtag_master_drv : command-driven JTAG initiator driving TCK/TMS/TDI       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module jtag_master_drv #(
    parameter int DATA_W = 32,
    parameter int DIV    = 2
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic [1:0]                cmd_op_i,
    input  logic [$clog2(DATA_W):0]   cmd_len_i,
    input  logic [DATA_W-1:0]         cmd_data_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [DATA_W-1:0]         rsp_data_o,
    output logic                      busy_o,
    output logic                      tck_o,
    output logic                      tms_o,
    output logic                      tdi_o,
    input  logic                      tdo_i
);

    localparam int LEN_W = $clog2(DATA_W) + 1;
    localparam int IDX_W = LEN_W + 1;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   cap_q, cap_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                tck_q, tck_d;
    logic                tms_q, tms_d;
    logic                tdi_q, tdi_d;

    logic [LEN_W-1:0]    len_clamped;
    logic [IDX_W-1:0]    next_idx;

    // TCKs spent in the TAP path before the first shift bit
    function automatic logic [IDX_W-1:0] pre_len(input logic [1:0] op);
        case (op)
            2'd1:    return IDX_W'(4);
            2'd2:    return IDX_W'(3);
            default: return '0;
        endcase
    endfunction

    function automatic logic [IDX_W-1:0] tck_count(input logic [1:0] op,
                                                   input logic [LEN_W-1:0] len);
        logic [IDX_W-1:0] l;
        l = IDX_W'(len);
        case (op)
            2'd0:    return IDX_W'(6);
            2'd3:    return l;
            default: return (len == '0) ? '0 : l + pre_len(op) + IDX_W'(2);
        endcase
    endfunction

    function automatic logic in_shift(input logic [1:0] op, input logic [LEN_W-1:0] len,
                                      input logic [IDX_W-1:0] k);
        logic [IDX_W-1:0] p;
        p = pre_len(op);
        return ((op == 2'd1) || (op == 2'd2)) && (k >= p) && (k < p + IDX_W'(len));
    endfunction

    function automatic logic tms_at(input logic [1:0] op, input logic [LEN_W-1:0] len,
                                    input logic [IDX_W-1:0] k);
        logic [IDX_W-1:0] p;
        logic [IDX_W-1:0] l;
        p = pre_len(op);
        l = IDX_W'(len);
        if (op == 2'd0) return k < IDX_W'(5);
        if (op == 2'd3) return 1'b0;
        if (k < p)      return (op == 2'd1) ? (k < IDX_W'(2)) : (k == '0);
        if (k < p + l)  return k == p + l - IDX_W'(1);
        return k == p + l;
    endfunction

    function automatic logic tdi_at(input logic [1:0] op, input logic [LEN_W-1:0] len,
                                    input logic [DATA_W-1:0] data,
                                    input logic [IDX_W-1:0] k);
        logic [DATA_W-1:0] sh;
        sh = data >> (k - pre_len(op));
        return in_shift(op, len, k) & sh[0];
    endfunction

    assign len_clamped = (cmd_len_i > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : cmd_len_i;
    assign next_idx    = idx_q + IDX_W'(1);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        len_d   = len_q;
        data_d  = data_q;
        cap_d   = cap_q;
        idx_d   = idx_q;
        div_d   = div_q;
        tck_d   = tck_q;
        tms_d   = tms_q;
        tdi_d   = tdi_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    op_d   = cmd_op_i;
                    len_d  = len_clamped;
                    data_d = cmd_data_i;
                    cap_d  = '0;
                    idx_d  = '0;
                    div_d  = '0;
                    tck_d  = 1'b0;
                    // zero-length commands answer immediately without touching the pins
                    if (tck_count(cmd_op_i, len_clamped) == '0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_RUN;
                        tms_d   = tms_at(cmd_op_i, len_clamped, '0);
                        tdi_d   = tdi_at(cmd_op_i, len_clamped, cmd_data_i, '0);
                    end
                end
            end
            S_RUN: begin
                if (div_q == DIV_W'(DIV - 1)) begin
                    div_d = '0;
                    tck_d = ~tck_q;
                    if (!tck_q) begin
                        if (in_shift(op_q, len_q, idx_q))
                            cap_d = cap_q | (DATA_W'(tdo_i) << (idx_q - pre_len(op_q)));
                    end else if (next_idx == tck_count(op_q, len_q)) begin
                        state_d = S_RESP;
                        tms_d   = 1'b0;
                        tdi_d   = 1'b0;
                    end else begin
                        idx_d = next_idx;
                        tms_d = tms_at(op_q, len_q, next_idx);
                        tdi_d = tdi_at(op_q, len_q, data_q, next_idx);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            len_q   <= '0;
            data_q  <= '0;
            cap_q   <= '0;
            idx_q   <= '0;
            div_q   <= '0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            len_q   <= len_d;
            data_q  <= data_d;
            cap_q   <= cap_d;
            idx_q   <= idx_d;
            div_q   <= div_d;
            tck_q   <= tck_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
        end
    end

    assign cmd_ready_o = (state_q == S_IDLE);
    assign rsp_valid_o = (state_q == S_RESP);
    assign busy_o      = (state_q == S_RUN);
    assign rsp_data_o  = cap_q;
    assign tck_o       = tck_q;
    assign tms_o       = tms_q;
    assign tdi_o       = tdi_q;

endmodule
`default_nettype wire
